instr_fetch_buffer: RTL and testbench

Parametrised successor to the single-entry instruction register. It holds a DEPTH-entry queue of fetched instruction words between memory and the controller. Fetch can therefore run ahead of execution. The head entry is presented already split into opcode and operand. Each word the controller consumes is also latched into a retained instruction register, so the opcode and operand stay stable for the whole execute phase.

---
 rtl/instr_fetch_buffer.sv | 105 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// DEPTH-entry instruction fetch queue feeding a retained instruction register.
// Optional combinational empty-queue bypass is enabled by defining IFB_BYPASS_EN.
module instr_fetch_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            inst_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-ADDR_WIDTH-1:0] head_opcode,
    output logic [ADDR_WIDTH-1:0]            head_operand,
    output logic [DATA_WIDTH-ADDR_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]            operand,
    output logic [$clog2(DEPTH):0]           count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  empty;
    logic                  full;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IFB_BYPASS_EN
    assign bypass = empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = !full;
    assign out_valid = !empty || bypass;
    assign pop       = out_valid && out_ready;
    // A pop while empty can only be a bypassed word, which never touches the queue.
    assign deq       = pop && !empty;
    assign push      = in_valid && in_ready && !(bypass && out_ready);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        head_word = '0;
        if (!empty) begin
            head_word = mem[rd_ptr];
        end else if (bypass) begin
            head_word = inst_in;
        end
    end

    assign head_opcode  = head_word[DATA_WIDTH-1:ADDR_WIDTH];
    assign head_operand = head_word[ADDR_WIDTH-1:0];
    assign opcode       = ir_q[DATA_WIDTH-1:ADDR_WIDTH];
    assign operand      = ir_q[ADDR_WIDTH-1:0];
    assign count        = count_q;

    // NOTE: storage has no reset; entries are unobservable until written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= inst_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ir_q    <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) begin
                ir_q <= head_word;
            end
            case ({push, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (DEPTH=4); empty-path check follows IFB_BYPASS_EN.
module tb_instr_fetch_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] inst_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] head_opcode;
    logic [4:0] head_operand;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    instr_fetch_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .head_opcode(head_opcode), .head_operand(head_operand),
        .opcode(opcode), .operand(operand), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fill_words [4] = '{8'h21, 8'h42, 8'h63, 8'h84};
    logic [7:0] exp_ir;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst_in = '0; out_ready = 1'b0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_ir", {24'h0, opcode, operand}, 0);
        check("rst_head", {24'h0, head_opcode, head_operand}, 0);
        #10 rst_n = 1'b1;
        tick();

        // Fill to DEPTH with the controller stalled.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; inst_in = fill_words[i];
            tick();
        end
        check("fill_count", 32'(count), 4);
        check("fill_in_ready", 32'(in_ready), 0);
        check("fill_head", {24'h0, head_opcode, head_operand}, 32'h21);
        inst_in = 8'hA5;
        tick();
        check("full_reject_count", 32'(count), 4);
        in_valid = 1'b0;

        // Drain: IR sequence 1/01, 2/02, 3/03, 4/04.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_opcode%0d", i), 32'(opcode), 32'(i + 1));
            check($sformatf("drain_operand%0d", i), 32'(operand), 32'(i + 1));
        end
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
        out_ready = 1'b0;

        // Prime to 2 entries, then 8 cycles of simultaneous push/pop.
        in_valid = 1'b1; inst_in = 8'hF0; tick();
        inst_in = 8'hF1; tick();
        check("prime_count", 32'(count), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst_in = 8'(i + 1);
            exp_ir = (i == 0) ? 8'hF0 : (i == 1) ? 8'hF1 : 8'(i - 1);
            tick();
            check($sformatf("stream_count%0d", i), 32'(count), 2);
            check($sformatf("stream_ir%0d", i), {24'h0, opcode, operand}, 32'(exp_ir));
        end
        check("stream_head", {24'h0, head_opcode, head_operand}, 32'h07);

        // Raise to 3 entries, then flush against a simultaneous push and pop.
        out_ready = 1'b0; inst_in = 8'h09; tick();
        check("preflush_count", 32'(count), 3);
        flush = 1'b1; in_valid = 1'b1; inst_in = 8'hE7; out_ready = 1'b1;
        tick();
        check("flush_count", 32'(count), 0);
        check("flush_ir_kept", {24'h0, opcode, operand}, 32'h06);
        check("flush_out_valid", 32'(out_valid), 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_e7_dropped", 32'(count), 0);
        check("flush_ir_still", {24'h0, opcode, operand}, 32'h06);

        // Empty-path behaviour with 0xC9 and out_ready=1.
        in_valid = 1'b1; inst_in = 8'hC9; out_ready = 1'b1;
        #1;
`ifdef IFB_BYPASS_EN
        check("byp_out_valid", 32'(out_valid), 1);
        check("byp_head", {24'h0, head_opcode, head_operand}, 32'hC9);
        tick();
        in_valid = 1'b0;
        check("byp_opcode", 32'(opcode), 6);
        check("byp_operand", 32'(operand), 32'h09);
        check("byp_count", 32'(count), 0);
`else
        check("nobyp_out_valid", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check("nobyp_count", 32'(count), 1);
        check("nobyp_ir_hold", {24'h0, opcode, operand}, 32'h06);
        tick();
        check("nobyp_opcode", 32'(opcode), 6);
        check("nobyp_operand", 32'(operand), 32'h09);
        check("nobyp_count_after", 32'(count), 0);
`endif

        // Async reset mid-cycle with 3 words queued.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_in = 8'(8'h30 + i);
            tick();
        end
        in_valid = 1'b0;
        check("prerst_count", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_opcode", 32'(opcode), 0);
        check("arst_operand", 32'(operand), 0);
        #10 rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
